// File: rtl/host_mem_wr_engine.sv
// Host-memory write initiator: streams a seeded line pattern over the Avalon-MM
// write channel in bursts, bounding outstanding bursts and collecting responses.
module host_mem_wr_engine #(
   parameter int ADDR_WIDTH      = 48,
   parameter int DATA_WIDTH      = 512,
   parameter int BURST_CNT_WIDTH = 3,
   parameter int MAX_OUTSTANDING = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ADDR_WIDTH-1:0]      base_addr,
   input  logic [31:0]                num_lines,
   input  logic [BURST_CNT_WIDTH-1:0] burst_len,
   input  logic [63:0]                seed,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [31:0]                lines_written,
   output logic [ADDR_WIDTH-1:0]      wr_address,
   output logic                       wr_write,
   output logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
   output logic [DATA_WIDTH-1:0]      wr_writedata,
   output logic [DATA_WIDTH/8-1:0]    wr_byteenable,
   input  logic                       wr_waitrequest,
   input  logic                       wr_writeresponsevalid,
   input  logic [1:0]                 wr_response
);

   localparam int LANES = DATA_WIDTH / 64;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DRAIN, S_DONE} state_t;

   state_t                     state, state_nxt;
   logic [BURST_CNT_WIDTH-1:0] blen_q, beat_rem, start_bc, next_bc;
   logic [31:0]                lines_left;
   logic [63:0]                lane_q;
   logic [OUT_W-1:0]           outstanding, out_nxt;
   logic                       cmd_start, accept, last_beat, final_beat, resp_vld, can_issue;

   function automatic logic [BURST_CNT_WIDTH-1:0] eff_len(input logic [BURST_CNT_WIDTH-1:0] b);
      if (b == BURST_CNT_WIDTH'(2) || b == BURST_CNT_WIDTH'(4)) return b;
      return BURST_CNT_WIDTH'(1);
   endfunction

   function automatic logic [BURST_CNT_WIDTH-1:0] clip_len(input logic [BURST_CNT_WIDTH-1:0] b,
                                                           input logic [31:0] left);
      if (left < 32'(b)) return left[BURST_CNT_WIDTH-1:0];
      return b;
   endfunction

   assign cmd_start     = start && (state == S_IDLE);
   assign accept        = wr_write && !wr_waitrequest;
   assign last_beat     = accept && (beat_rem == '0);
   assign final_beat    = accept && (lines_left == 32'd1);
   assign resp_vld      = wr_writeresponsevalid && (state != S_IDLE);
   assign start_bc      = clip_len(eff_len(burst_len), num_lines);
   assign next_bc       = clip_len(blen_q, lines_left - 32'd1);
   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign wr_byteenable = '1;

   // Lookahead count lets a freed slot re-open the bus on the very next cycle
   always_comb begin
      out_nxt = outstanding;
      if (last_beat && !resp_vld)
         out_nxt = outstanding + OUT_W'(1);
      else if (!last_beat && resp_vld && outstanding != '0)
         out_nxt = outstanding - OUT_W'(1);
   end

   assign can_issue = (out_nxt < OUT_W'(MAX_OUTSTANDING));

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (num_lines == 32'd0) ? S_DONE : S_WRITE;
         S_WRITE: if (final_beat) state_nxt = S_DRAIN;
         S_DRAIN: if (outstanding == '0 && !wr_writeresponsevalid) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         error         <= 1'b0;
         lines_written <= '0;
         lines_left    <= '0;
         blen_q        <= '0;
         beat_rem      <= '0;
         lane_q        <= '0;
         outstanding   <= '0;
         wr_write      <= 1'b0;
         wr_address    <= '0;
         wr_burstcount <= '0;
         wr_writedata  <= '0;
      end else begin
         outstanding <= out_nxt;
         if (cmd_start) begin
            error         <= 1'b0;
            lines_written <= '0;
            lines_left    <= num_lines;
            blen_q        <= eff_len(burst_len);
            lane_q        <= seed;
            wr_address    <= base_addr;
            wr_burstcount <= start_bc;
            beat_rem      <= start_bc - BURST_CNT_WIDTH'(1);
            wr_writedata  <= {LANES{seed}};
            wr_write      <= (num_lines != 32'd0);
         end else if (state == S_WRITE) begin
            if (accept) begin
               lines_written <= lines_written + 32'd1;
               lines_left    <= lines_left - 32'd1;
               lane_q        <= lane_q + 64'd1;
               if (lines_left == 32'd1) begin
                  wr_write <= 1'b0;
               end else begin
                  wr_writedata <= {LANES{lane_q + 64'd1}};
                  if (beat_rem != '0) begin
                     beat_rem <= beat_rem - BURST_CNT_WIDTH'(1);
                  end else begin
                     // Next burst is staged even when throttled, so a stall only drops wr_write
                     wr_address    <= wr_address + ADDR_WIDTH'(wr_burstcount);
                     wr_burstcount <= next_bc;
                     beat_rem      <= next_bc - BURST_CNT_WIDTH'(1);
                     wr_write      <= can_issue;
                  end
               end
            end else if (!wr_write) begin
               wr_write <= can_issue;
            end
         end
         if (resp_vld && wr_response != 2'b00)
            error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_host_mem_wr_engine.sv
// Scoreboard bench for host_mem_wr_engine: a burst-list reference model feeds an
// expected-beat queue that a negedge monitor drains against the write channel.
module tb_host_mem_wr_engine;

   localparam int AW    = 48;
   localparam int DW    = 512;
   localparam int BW    = 3;
   localparam int MAXO  = 2;
   localparam int LANES = DW / 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [31:0]   num_lines = '0;
   logic [BW-1:0] burst_len = '0;
   logic [63:0]   seed = '0;
   logic          busy, done, error;
   logic [31:0]   lines_written;
   logic [AW-1:0] wr_address;
   logic          wr_write;
   logic [BW-1:0] wr_burstcount;
   logic [DW-1:0] wr_writedata;
   logic [DW/8-1:0] wr_byteenable;
   logic          wr_waitrequest;
   logic          wr_writeresponsevalid;
   logic [1:0]    wr_response;

   host_mem_wr_engine #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .num_lines(num_lines), .burst_len(burst_len), .seed(seed),
      .busy(busy), .done(done), .error(error), .lines_written(lines_written),
      .wr_address(wr_address), .wr_write(wr_write), .wr_burstcount(wr_burstcount),
      .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
      .wr_waitrequest(wr_waitrequest), .wr_writeresponsevalid(wr_writeresponsevalid),
      .wr_response(wr_response)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [BW-1:0] bc;
      logic [63:0]   lane;
      bit            last;
   } beat_t;

   beat_t      exp_q[$];
   logic [1:0] resp_q[$];

   int checks = 0, failures = 0, cyc = 0;
   int stall_pct = 0, resp_budget = -1;
   bit resp_rand = 1'b1;
   int burst_no = 0, err_burst = -1, resp_seen = 0, beats_seen = 0;
   int first_beat_cyc = 0, last_beat_cyc = 0, done_cnt = 0, done_base = 0;
   int exp_bursts = 0, start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic int eff(input logic [BW-1:0] b);
      case (b)
         3'd2:    return 2;
         3'd4:    return 4;
         default: return 1;
      endcase
   endfunction

   // Slave backpressure
   initial begin
      wr_waitrequest = 1'b0;
      forever begin
         @(posedge clk); #1;
         wr_waitrequest = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      end
   end

   // Slave responder: one response per completed burst, optionally rationed
   initial begin
      wr_writeresponsevalid = 1'b0;
      wr_response = 2'b00;
      forever begin
         @(posedge clk); #2;
         wr_writeresponsevalid = 1'b0;
         wr_response = 2'b00;
         if (resp_q.size() > 0 && resp_budget != 0 && (!resp_rand || $urandom_range(1) == 1)) begin
            wr_writeresponsevalid = 1'b1;
            wr_response = resp_q.pop_front();
            if (resp_budget > 0) resp_budget--;
         end
      end
   end

   beat_t         mb;
   bit            prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [BW-1:0] prev_bc;
   logic [DW-1:0] prev_data;
   logic [63:0]   bad_lane;
   bit            lanes_ok;

   // Monitor
   always @(negedge clk) begin
      if (prev_stall)
         chk("stall_hold", wr_write && wr_address == prev_addr && wr_burstcount == prev_bc &&
             wr_writedata == prev_data, {15'd0, wr_write, wr_address}, {15'd0, 1'b1, prev_addr});
      if (wr_write && !wr_waitrequest) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1'b0, 64'(wr_address), 64'd0);
         end else begin
            mb = exp_q.pop_front();
            chk("wr_address", wr_address == mb.addr, 64'(wr_address), 64'(mb.addr));
            chk("wr_burstcount", wr_burstcount == mb.bc, 64'(wr_burstcount), 64'(mb.bc));
            lanes_ok = 1'b1;
            bad_lane = mb.lane;
            for (int l = 0; l < LANES; l++)
               if (wr_writedata[l*64 +: 64] != mb.lane) begin
                  lanes_ok = 1'b0;
                  bad_lane = wr_writedata[l*64 +: 64];
               end
            chk("wr_writedata", lanes_ok, bad_lane, mb.lane);
            chk("wr_byteenable", &wr_byteenable, 64'(wr_byteenable[63:0]), {64{1'b1}});
            if (mb.last) begin
               resp_q.push_back((burst_no == err_burst) ? 2'b10 : 2'b00);
               burst_no++;
            end
         end
         if (beats_seen == 0) first_beat_cyc = cyc;
         last_beat_cyc = cyc;
         beats_seen++;
      end
      if (wr_writeresponsevalid && busy) resp_seen++;
      if (done) done_cnt++;
      prev_stall = wr_write && wr_waitrequest;
      prev_addr  = wr_address;
      prev_bc    = wr_burstcount;
      prev_data  = wr_writedata;
   end

   // Reference model: split the command into bursts and queue every expected beat
   task automatic issue_cmd(input logic [AW-1:0] b, input int n, input logic [BW-1:0] bl,
                            input logic [63:0] sd, input int eb);
      int e, rem, k;
      logic [AW-1:0] a;
      logic [63:0]   ln;
      e = eff(bl); rem = n; a = b; ln = sd;
      @(posedge clk); #1;
      exp_bursts = 0;
      while (rem > 0) begin
         k = (rem < e) ? rem : e;
         for (int j = 0; j < k; j++) begin
            exp_q.push_back('{a, BW'(k), ln, (j == k - 1)});
            ln = ln + 64'd1;
         end
         a = a + AW'(k);
         rem -= k;
         exp_bursts++;
      end
      burst_no = 0; err_burst = eb; resp_seen = 0; beats_seen = 0; done_base = done_cnt;
      start = 1'b1; base_addr = b; num_lines = 32'(n); burst_len = bl; seed = sd; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = AW'({$urandom, $urandom});
      num_lines = $urandom;
      seed = {$urandom, $urandom};
   endtask

   task automatic wait_done(input int n, input bit exp_err);
      bit got = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      chk("done_seen", got, 64'(got), 64'd1);
      if (got) begin
         chk("lines_written", lines_written == 32'(n), 64'(lines_written), 64'(n));
         chk("error_at_done", error == exp_err, 64'(error), 64'(exp_err));
         chk("busy_at_done", busy, 64'(busy), 64'd1);
         chk("exp_q_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
         chk("resp_count", resp_seen == exp_bursts, 64'(resp_seen), 64'(exp_bursts));
      end
      repeat (5) @(negedge clk);
      chk("done_once", done_cnt == done_base + 1, 64'(done_cnt - done_base), 64'd1);
      chk("busy_after", !busy, 64'(busy), 64'd0);
   endtask

   task automatic chk_reset_values();
      chk("rst_busy", !busy, 64'(busy), 64'd0);
      chk("rst_done", !done, 64'(done), 64'd0);
      chk("rst_error", !error, 64'(error), 64'd0);
      chk("rst_wr_write", !wr_write, 64'(wr_write), 64'd0);
      chk("rst_lines", lines_written == 32'd0, 64'(lines_written), 64'd0);
      chk("rst_addr", wr_address == '0, 64'(wr_address), 64'd0);
      chk("rst_bc", wr_burstcount == '0, 64'(wr_burstcount), 64'd0);
      chk("rst_data", wr_writedata == '0, wr_writedata[63:0], 64'd0);
      chk("rst_be", &wr_byteenable, 64'(wr_byteenable[63:0]), {64{1'b1}});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [AW-1:0] rb;
      logic [BW-1:0] rbl;
      int rn;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_values();
      @(posedge clk); #1;
      reset = 1'b0;

      // Two full bursts, no backpressure, exact beat timing
      stall_pct = 0; resp_rand = 1'b1; resp_budget = -1;
      issue_cmd(48'h100, 8, 3'd4, 64'd5, -1);
      wait_done(8, 1'b0);
      chk("first_beat_cyc", first_beat_cyc == start_cyc + 1, 64'(first_beat_cyc - start_cyc), 64'd1);
      chk("last_beat_cyc", last_beat_cyc == start_cyc + 8, 64'(last_beat_cyc - start_cyc), 64'd8);

      // Short tail burst, plus a start pulse while busy that must be ignored
      issue_cmd(48'h200, 7, 3'd4, {$urandom, $urandom}, -1);
      @(posedge clk); #1;
      start = 1'b1; num_lines = 32'd3; burst_len = 3'd1; base_addr = 48'h999;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(7, 1'b0);

      // Randomized commands under 50% backpressure; first seed exercises 64-bit wrap
      stall_pct = 50;
      for (int it = 0; it < 8; it++) begin
         rbl = BW'($urandom_range(7));
         rn  = $urandom_range(20);
         rb  = AW'({$urandom, $urandom}) & ~AW'(eff(rbl) - 1);
         issue_cmd(rb, rn, rbl, (it == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {$urandom, $urandom}, -1);
         wait_done(rn, 1'b0);
      end

      // Outstanding limit with held responses
      stall_pct = 0; resp_rand = 1'b0; resp_budget = 0;
      issue_cmd(48'h40, 5, 3'd1, {$urandom, $urandom}, -1);
      repeat (10) @(negedge clk);
      chk("held_beats", beats_seen == 2, 64'(beats_seen), 64'd2);
      chk("held_wr_write", !wr_write, 64'(wr_write), 64'd0);
      @(posedge clk); #1; resp_budget = 1;
      repeat (10) @(negedge clk);
      chk("release_one", beats_seen == 3, 64'(beats_seen), 64'd3);
      @(posedge clk); #1; resp_budget = 2;
      repeat (10) @(negedge clk);
      chk("coincident_resp", beats_seen == 5, 64'(beats_seen), 64'd5);
      @(posedge clk); #1; resp_budget = -1; resp_rand = 1'b1;
      wait_done(5, 1'b0);

      // Error response on the first of three bursts, then cleared by the next start
      stall_pct = 30;
      issue_cmd(48'h80, 12, 3'd4, {$urandom, $urandom}, 0);
      wait_done(12, 1'b1);
      chk("error_sticky", error, 64'(error), 64'd1);
      issue_cmd(48'h90, 4, 3'd2, {$urandom, $urandom}, -1);
      @(negedge clk);
      chk("error_cleared", !error, 64'(error), 64'd0);
      wait_done(4, 1'b0);

      // Reset mid-burst, then a late error response that must be ignored
      stall_pct = 0; resp_rand = 1'b0; resp_budget = 0;
      issue_cmd(48'h300, 8, 3'd4, {$urandom, $urandom}, -1);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      exp_q.delete();
      resp_q.delete();
      @(negedge clk);
      chk_reset_values();
      @(posedge clk); #1;
      resp_q.push_back(2'b10);
      resp_budget = -1;
      repeat (4) @(negedge clk);
      chk("late_resp_error", !error, 64'(error), 64'd0);
      chk("late_resp_busy", !busy, 64'(busy), 64'd0);
      resp_rand = 1'b1;
      issue_cmd(48'h0, 0, 3'd4, {$urandom, $urandom}, -1);
      @(negedge clk);
      chk("zero_busy_c1", busy, 64'(busy), 64'd1);
      chk("zero_done_c1", done, 64'(done), 64'd1);
      chk("zero_no_write", !wr_write, 64'(wr_write), 64'd0);
      @(negedge clk);
      chk("zero_busy_c2", !busy, 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("zero_done_once", done_cnt == done_base + 1, 64'(done_cnt - done_base), 64'd1);
      issue_cmd(48'h400, 3, 3'd2, {$urandom, $urandom}, -1);
      wait_done(3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
